// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB with a
// memory-ready handshake, wait timeout and a sticky error state.
//
// state  | meaning
// FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
// DECODE | read register file, resolve j/jr, trap illegal opcodes
// EXEC   | ALU operation, branch resolution
// MEM    | data memory access for lw/sw
// WB     | register file write
// ERR    | sticky fault, cleared only by reset
module mips_multicycle_control #(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Function,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic [1:0]         pc_src,
    output logic               RegRead,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUsrc,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IorD,
    output logic               MemtoReg,
    output logic [ALUOP_W-1:0] ALU_Op,
    output logic [2:0]         state,
    output logic [1:0]         err_code,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_NOR  = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SUBU = 3'd6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       err_q;

    logic       legal, is_rtype, use_imm;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jr;
    logic [2:0] alu_code;

    always_comb begin
        legal    = 1'b0;
        is_rtype = 1'b0;
        use_imm  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        alu_code = ALU_ADD;
        case (Opcode)
            6'h00: begin
                is_rtype = 1'b1;
                legal    = 1'b1;
                case (Function)
                    6'h20: alu_code = ALU_ADD;
                    6'h24: alu_code = ALU_AND;
                    6'h25: alu_code = ALU_OR;
                    6'h27: alu_code = ALU_NOR;
                    6'h2a: alu_code = ALU_SLT;
                    6'h22: alu_code = ALU_SUB;
                    6'h23: alu_code = ALU_SUBU;
                    6'h08: is_jr    = 1'b1;
                    default: legal  = 1'b0;
                endcase
            end
            6'h08: begin legal = 1'b1; use_imm = 1'b1; alu_code = ALU_ADD; end
            6'h0c: begin legal = 1'b1; use_imm = 1'b1; alu_code = ALU_AND; end
            6'h0d: begin legal = 1'b1; use_imm = 1'b1; alu_code = ALU_OR;  end
            6'h0a: begin legal = 1'b1; use_imm = 1'b1; alu_code = ALU_SLT; end
            6'h23: begin legal = 1'b1; use_imm = 1'b1; is_lw = 1'b1; end
            6'h2b: begin legal = 1'b1; use_imm = 1'b1; is_sw = 1'b1; end
            6'h02: begin legal = 1'b1; is_j = 1'b1; end
            6'h04: begin legal = 1'b1; is_beq = 1'b1; alu_code = ALU_SUB; end
            6'h05: begin legal = 1'b1; is_bne = 1'b1; alu_code = ALU_SUB; end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 2'b00;
        end else begin
            case (state_q)
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        cnt_q <= '0;
                        if (state_q == S_FETCH) state_q <= S_DECODE;
                        else if (is_lw)         state_q <= S_WB;
                        else                    state_q <= S_FETCH;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        err_q   <= 2'b10;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        err_q   <= 2'b01;
                        state_q <= S_ERR;
                    end else if (is_j || is_jr) state_q <= S_FETCH;
                    else                        state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (is_lw || is_sw)        state_q <= S_MEM;
                    else if (is_beq || is_bne) state_q <= S_FETCH;
                    else                       state_q <= S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        pc_src   = 2'b00;
        RegRead  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ALUsrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        MemtoReg = 1'b0;
        ALU_Op   = '1;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_DECODE: begin
                RegRead = 1'b1;
                if (legal && is_j) begin
                    PCWrite = 1'b1;
                    pc_src  = 2'b10;
                end else if (legal && is_jr) begin
                    PCWrite = 1'b1;
                    pc_src  = 2'b11;
                end
            end
            S_EXEC: begin
                RegRead = 1'b1;
                ALUsrc  = use_imm;
                ALU_Op  = ALUOP_W'(alu_code);
                if (is_beq || is_bne) begin
                    pc_src  = 2'b01;
                    PCWrite = is_beq ? Zero : !Zero;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                ALUsrc   = 1'b1;
                ALU_Op   = ALUOP_W'(ALU_ADD);
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_rtype;
                MemtoReg = is_lw;
            end
            default: ;
        endcase
    end

    assign state    = state_q;
    assign err_code = err_q;
    assign busy     = (state_q != S_FETCH);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed table-driven bench for the multi-cycle MIPS control FSM (TIMEOUT=4).
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Function;
    logic       Zero, mem_ready;
    logic       PCWrite, IRWrite, RegRead, RegWrite, RegDst, ALUsrc;
    logic       MemRead, MemWrite, IorD, MemtoReg, busy;
    logic [1:0] pc_src, err_code;
    logic [3:0] ALU_Op;
    logic [2:0] state;

    mips_multicycle_control #(.ALUOP_W(4), .TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Function(Function),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .pc_src(pc_src), .RegRead(RegRead), .RegWrite(RegWrite), .RegDst(RegDst),
        .ALUsrc(ALUsrc), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .MemtoReg(MemtoReg), .ALU_Op(ALU_Op), .state(state), .err_code(err_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [2:0]  st;
        logic [18:0] ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [3:0] NONE = 4'hf;

    // {PCWrite,IRWrite,pc_src,RegRead,RegWrite,RegDst,ALUsrc,MemRead,MemWrite,IorD,MemtoReg,ALU_Op,err_code,busy}
    function automatic logic [18:0] ctl(input logic pcw, input logic irw, input logic [1:0] pcs,
                                        input logic rr, input logic rw, input logic rd, input logic as,
                                        input logic mr, input logic mw, input logic iord, input logic m2r,
                                        input logic [3:0] alu, input logic [1:0] err, input logic bsy);
        return {pcw, irw, pcs, rr, rw, rd, as, mr, mw, iord, m2r, alu, err, bsy};
    endfunction

    function automatic logic [18:0] actual();
        return {PCWrite, IRWrite, pc_src, RegRead, RegWrite, RegDst, ALUsrc, MemRead,
                MemWrite, IorD, MemtoReg, ALU_Op, err_code, busy};
    endfunction

    task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr, input logic [2:0] st, input logic [18:0] c);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.st = st; v.ctl = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic [18:0] c);
        n_cmp++;
        if (state !== st || actual() !== c) begin
            n_bad++;
            $display("FAIL %s: state=%0d ctl=%05h, required state=%0d ctl=%05h",
                     name, state, actual(), st, c);
        end
    endtask

    logic [18:0] f_idle, f_rdy, dec, wb_r, wb_i, wb_lw, ex_add, ex_ori, ex_nor, ex_ls;
    logic [18:0] ex_br_t, ex_br_n, mem_lw, mem_sw, dec_j, dec_jr, err10, err01;

    initial begin
        f_idle  = ctl(0,0,2'b00,0,0,0,0,1,0,0,0,NONE,2'b00,0);
        f_rdy   = ctl(1,1,2'b00,0,0,0,0,1,0,0,0,NONE,2'b00,0);
        dec     = ctl(0,0,2'b00,1,0,0,0,0,0,0,0,NONE,2'b00,1);
        dec_j   = ctl(1,0,2'b10,1,0,0,0,0,0,0,0,NONE,2'b00,1);
        dec_jr  = ctl(1,0,2'b11,1,0,0,0,0,0,0,0,NONE,2'b00,1);
        ex_add  = ctl(0,0,2'b00,1,0,0,0,0,0,0,0,4'd0,2'b00,1);
        ex_ori  = ctl(0,0,2'b00,1,0,0,1,0,0,0,0,4'd2,2'b00,1);
        ex_nor  = ctl(0,0,2'b00,1,0,0,0,0,0,0,0,4'd3,2'b00,1);
        ex_ls   = ctl(0,0,2'b00,1,0,0,1,0,0,0,0,4'd0,2'b00,1);
        ex_br_t = ctl(1,0,2'b01,1,0,0,0,0,0,0,0,4'd4,2'b00,1);
        ex_br_n = ctl(0,0,2'b01,1,0,0,0,0,0,0,0,4'd4,2'b00,1);
        mem_lw  = ctl(0,0,2'b00,0,0,0,1,1,0,1,0,4'd0,2'b00,1);
        mem_sw  = ctl(0,0,2'b00,0,0,0,1,0,1,1,0,4'd0,2'b00,1);
        wb_r    = ctl(0,0,2'b00,0,1,1,0,0,0,0,0,NONE,2'b00,1);
        wb_i    = ctl(0,0,2'b00,0,1,0,0,0,0,0,0,NONE,2'b00,1);
        wb_lw   = ctl(0,0,2'b00,0,1,0,0,0,0,0,1,NONE,2'b00,1);
        err10   = ctl(0,0,2'b00,0,0,0,0,0,0,0,0,NONE,2'b10,1);
        err01   = ctl(0,0,2'b00,0,0,0,0,0,0,0,0,NONE,2'b01,1);

        push(1, 6'h00, 6'h20, 0, 0, 3'd0, f_idle);
        // add: 0,1,2,4
        push(0, 6'h00, 6'h20, 0, 1, 3'd0, f_rdy);
        push(0, 6'h00, 6'h20, 0, 0, 3'd1, dec);
        push(0, 6'h00, 6'h20, 0, 0, 3'd2, ex_add);
        push(0, 6'h00, 6'h20, 0, 0, 3'd4, wb_r);
        // ori
        push(0, 6'h0d, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h0d, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h0d, 6'h00, 0, 0, 3'd2, ex_ori);
        push(0, 6'h0d, 6'h00, 0, 0, 3'd4, wb_i);
        // nor
        push(0, 6'h00, 6'h27, 0, 1, 3'd0, f_rdy);
        push(0, 6'h00, 6'h27, 0, 0, 3'd1, dec);
        push(0, 6'h00, 6'h27, 0, 0, 3'd2, ex_nor);
        push(0, 6'h00, 6'h27, 0, 0, 3'd4, wb_r);
        // lw with mem_ready delayed 3 cycles
        push(0, 6'h23, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h23, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h23, 6'h00, 0, 0, 3'd2, ex_ls);
        push(0, 6'h23, 6'h00, 0, 0, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 0, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 0, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 1, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 0, 3'd4, wb_lw);
        // beq / bne, both Zero values
        push(0, 6'h04, 6'h00, 1, 1, 3'd0, f_rdy);
        push(0, 6'h04, 6'h00, 1, 0, 3'd1, dec);
        push(0, 6'h04, 6'h00, 1, 0, 3'd2, ex_br_t);
        push(0, 6'h04, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h04, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h04, 6'h00, 0, 0, 3'd2, ex_br_n);
        push(0, 6'h05, 6'h00, 1, 1, 3'd0, f_rdy);
        push(0, 6'h05, 6'h00, 1, 0, 3'd1, dec);
        push(0, 6'h05, 6'h00, 1, 0, 3'd2, ex_br_n);
        push(0, 6'h05, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h05, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h05, 6'h00, 0, 0, 3'd2, ex_br_t);
        // j then jr
        push(0, 6'h02, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h02, 6'h00, 0, 0, 3'd1, dec_j);
        push(0, 6'h00, 6'h08, 0, 1, 3'd0, f_rdy);
        push(0, 6'h00, 6'h08, 0, 0, 3'd1, dec_jr);
        // fetch timeout after 4 cycles, ERR sticky, reset recovers
        push(0, 6'h00, 6'h20, 0, 0, 3'd0, f_idle);
        push(0, 6'h00, 6'h20, 0, 0, 3'd0, f_idle);
        push(0, 6'h00, 6'h20, 0, 0, 3'd0, f_idle);
        push(0, 6'h00, 6'h20, 0, 0, 3'd0, f_idle);
        push(0, 6'h00, 6'h20, 0, 0, 3'd7, err10);
        push(0, 6'h00, 6'h20, 0, 1, 3'd7, err10);
        push(1, 6'h00, 6'h20, 0, 0, 3'd7, err10);
        // mem_ready on the last allowed cycle succeeds
        push(0, 6'h3f, 6'h00, 0, 0, 3'd0, f_idle);
        push(0, 6'h3f, 6'h00, 0, 0, 3'd0, f_idle);
        push(0, 6'h3f, 6'h00, 0, 0, 3'd0, f_idle);
        push(0, 6'h3f, 6'h00, 0, 1, 3'd0, f_rdy);
        // illegal opcode
        push(0, 6'h3f, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h3f, 6'h00, 0, 1, 3'd7, err01);
        push(1, 6'h3f, 6'h00, 0, 0, 3'd7, err01);
        // sw with reset mid-MEM
        push(0, 6'h2b, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h2b, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h2b, 6'h00, 0, 0, 3'd2, ex_ls);
        push(1, 6'h2b, 6'h00, 0, 0, 3'd3, mem_sw);
        push(0, 6'h2b, 6'h00, 0, 0, 3'd0, f_idle);
        // sw normal completion
        push(0, 6'h2b, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h2b, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h2b, 6'h00, 0, 0, 3'd2, ex_ls);
        push(0, 6'h2b, 6'h00, 0, 1, 3'd3, mem_sw);
        // lw MEM timeout
        push(0, 6'h23, 6'h00, 0, 1, 3'd0, f_rdy);
        push(0, 6'h23, 6'h00, 0, 0, 3'd1, dec);
        push(0, 6'h23, 6'h00, 0, 0, 3'd2, ex_ls);
        push(0, 6'h23, 6'h00, 0, 0, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 0, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 0, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 0, 3'd3, mem_lw);
        push(0, 6'h23, 6'h00, 0, 0, 3'd7, err10);

        reset = 1'b1; Opcode = 6'h00; Function = 6'h20; Zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; Opcode = vecs[i].op; Function = vecs[i].fn;
            Zero = vecs[i].z; mem_ready = vecs[i].mr;
            #1;
            check($sformatf("row%0d", i), vecs[i].st, vecs[i].ctl);
            @(negedge clk);
        end

        // Hand sequence: count FETCH cycles to timeout with a bounded wait.
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset", 3'd0, f_idle);
        begin
            int cycles = 0;
            while (state != 3'd7 && cycles < 20) begin
                @(negedge clk);
                cycles++;
            end
            #1;
            n_cmp++;
            if (cycles != 4) begin
                n_bad++;
                $display("FAIL timeout_cycles: got %0d, required 4", cycles);
            end
            check("timeout_err", 3'd7, err10);
        end

        // Reset must override ERR within one cycle.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("err_reset", 3'd0, f_idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
